// File: rtl/fp_mant_mul_pipe.sv
// fp_mant_mul_pipe: three-stage pipelined significand multiplier for the FPU
// multiply path. Operands (hidden bit included) are split into SPLIT_W-bit
// chunks, chunk partial products are registered, then summed, normalised and
// rounded to nearest-even.
//
// Optional feature: define FP_MUL_ROUND_MODE_EN to add the rnd_mode input
// (0 = round-to-nearest-even, 1 = truncate). Without it the block is RNE only.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready is combinational)
//   num1, num2           MANT_W-bit significands, MSB = hidden 1
//   rnd_mode             rounding mode (only with FP_MUL_ROUND_MODE_EN)
//   out_valid/out_ready  result handshake
//   resultF              rounded fraction, hidden bit dropped
//   normalize            unrounded product >= 2.0
//   rnd_ovf              rounding carried out of the fraction (resultF = 0)
//   inexact              guard or sticky bit nonzero
module fp_mant_mul_pipe #(
    parameter int unsigned MANT_W  = 24,
    parameter int unsigned SPLIT_W = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] num1,
    input  logic [MANT_W-1:0] num2,
`ifdef FP_MUL_ROUND_MODE_EN
    input  logic              rnd_mode,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-2:0] resultF,
    output logic              normalize,
    output logic              rnd_ovf,
    output logic              inexact
);

    localparam int unsigned NCH = MANT_W / SPLIT_W;
    localparam int unsigned NPP = NCH * NCH;
    localparam int unsigned PPW = 2 * SPLIT_W;
    localparam int unsigned PW  = 2 * MANT_W;
    localparam int unsigned FW  = MANT_W - 1;

    // Chunking only works when the significand splits evenly
    generate
        if (MANT_W % SPLIT_W != 0) begin : g_bad_split
            $error("fp_mant_mul_pipe: MANT_W must be a multiple of SPLIT_W");
        end
    endgenerate

    // Whole pipeline freezes while a finished result is not taken
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    logic              s1_v;
    logic [MANT_W-1:0] s1_a;
    logic [MANT_W-1:0] s1_b;
    logic              s2_v;
    logic [PPW-1:0]    s2_pp [NPP];
    logic              trunc;

    // Chunk partial products of the registered operands
    logic [PPW-1:0] pp_c [NPP];
    always_comb begin
        pp_c = '{default: '0};
        for (int i = 0; i < NCH; i++) begin
            for (int j = 0; j < NCH; j++) begin
                pp_c[i*NCH+j] = PPW'(s1_a[i*SPLIT_W +: SPLIT_W]) *
                                PPW'(s1_b[j*SPLIT_W +: SPLIT_W]);
            end
        end
    end

    // Exact product from the shifted partial products
    logic [PW-1:0] prod_c;
    always_comb begin
        prod_c = '0;
        for (int i = 0; i < NCH; i++) begin
            for (int j = 0; j < NCH; j++) begin
                prod_c = prod_c + (PW'(s2_pp[i*NCH+j]) << ((i + j) * SPLIT_W));
            end
        end
    end

    // Normalise, pick guard/sticky, round
    logic              nrm_c;
    logic [FW-1:0]     frac_c;
    logic              g_c;
    logic              s_c;
    logic              inc_c;
    logic [MANT_W-1:0] sum_c;
    always_comb begin
        nrm_c  = prod_c[PW-1];
        frac_c = '0;
        g_c    = 1'b0;
        s_c    = 1'b0;
        if (nrm_c) begin
            frac_c = prod_c[PW-2:MANT_W];
            g_c    = prod_c[MANT_W-1];
            s_c    = |prod_c[MANT_W-2:0];
        end else begin
            frac_c = prod_c[PW-3:MANT_W-1];
            g_c    = prod_c[MANT_W-2];
            s_c    = |prod_c[MANT_W-3:0];
        end
        inc_c = ~trunc & g_c & (s_c | frac_c[0]);
        // Carry into the top bit means the fraction wrapped to zero
        sum_c = {1'b0, frac_c} + MANT_W'(inc_c);
    end

    // Main pipeline registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_v      <= 1'b0;
            s2_pp     <= '{default: '0};
            out_valid <= 1'b0;
            resultF   <= '0;
            normalize <= 1'b0;
            rnd_ovf   <= 1'b0;
            inexact   <= 1'b0;
        end else if (!stall) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_a <= num1;
                s1_b <= num2;
            end
            s2_v <= s1_v;
            if (s1_v) begin
                s2_pp <= pp_c;
            end
            out_valid <= s2_v;
            if (s2_v) begin
                resultF   <= sum_c[FW-1:0];
                normalize <= nrm_c;
                rnd_ovf   <= sum_c[MANT_W-1];
                inexact   <= g_c | s_c;
            end
        end
    end

`ifdef FP_MUL_ROUND_MODE_EN
    // Rounding mode travels alongside its operands
    logic s1_rm;
    logic s2_rm;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_rm <= 1'b0;
            s2_rm <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                s1_rm <= rnd_mode;
            end
            if (s1_v) begin
                s2_rm <= s1_rm;
            end
        end
    end
    assign trunc = s2_rm;
`else
    assign trunc = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mant_mul_pipe.sv
// Directed bench for fp_mant_mul_pipe: three instances (24/12, 53/53, 11/11)
// share handshake controls; hand-computed vectors plus a 128-bit reference
// model for random and streamed operands.
module tb_fp_mant_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, in_valid, out_ready, rnd_mode;
    logic [23:0] a24, b24;
    logic [52:0] a53, b53;
    logic [10:0] a11, b11;

    logic ir24, ov24, n24, o24, x24;
    logic ir53, ov53, n53, o53, x53;
    logic ir11, ov11, n11, o11, x11;
    logic [22:0] r24;
    logic [51:0] r53;
    logic [9:0]  r11;

    int total = 0;
    int bad   = 0;

    fp_mant_mul_pipe #(.MANT_W(24), .SPLIT_W(12)) u24 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir24),
        .num1(a24), .num2(b24),
`ifdef FP_MUL_ROUND_MODE_EN
        .rnd_mode(rnd_mode),
`endif
        .out_valid(ov24), .out_ready(out_ready), .resultF(r24),
        .normalize(n24), .rnd_ovf(o24), .inexact(x24));

    fp_mant_mul_pipe #(.MANT_W(53), .SPLIT_W(53)) u53 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir53),
        .num1(a53), .num2(b53),
`ifdef FP_MUL_ROUND_MODE_EN
        .rnd_mode(rnd_mode),
`endif
        .out_valid(ov53), .out_ready(out_ready), .resultF(r53),
        .normalize(n53), .rnd_ovf(o53), .inexact(x53));

    fp_mant_mul_pipe #(.MANT_W(11), .SPLIT_W(11)) u11 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir11),
        .num1(a11), .num2(b11),
`ifdef FP_MUL_ROUND_MODE_EN
        .rnd_mode(rnd_mode),
`endif
        .out_valid(ov11), .out_ready(out_ready), .resultF(r11),
        .normalize(n11), .rnd_ovf(o11), .inexact(x11));

    typedef struct packed {
        logic        nrm;
        logic        ovf;
        logic        inx;
        logic [63:0] frac;
    } exp_t;

    function automatic exp_t mk(input logic n, input logic o, input logic x,
                                input logic [63:0] f);
        exp_t e;
        e.nrm = n; e.ovf = o; e.inx = x; e.frac = f;
        return e;
    endfunction

    // Reference: full-width product, then normalise and round
    function automatic exp_t model(input int w, input logic [63:0] a,
                                   input logic [63:0] b, input logic rm);
        logic [127:0] p, mask;
        logic [63:0]  f;
        logic         g, s, inc;
        int           sh;
        exp_t         e;
        p     = {64'd0, a} * {64'd0, b};
        e.nrm = p[2*w-1];
        sh    = e.nrm ? w : w - 1;
        f     = 64'((p >> sh) & ((128'd1 << (w - 1)) - 128'd1));
        g     = p[sh-1];
        mask  = (128'd1 << (sh - 1)) - 128'd1;
        s     = |(p & mask);
        inc   = !rm && g && (s || f[0]);
        f     = f + 64'(inc);
        e.ovf = (f >> (w - 1)) != 64'd0;
        if (e.ovf) f = 64'd0;
        e.frac = f;
        e.inx  = g | s;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic [63:0] r, input logic n,
                           input logic o, input logic x, input exp_t e);
        chk({tag, "_res"}, r, e.frac);
        chk({tag, "_nrm"}, 64'(n), 64'(e.nrm));
        chk({tag, "_ovf"}, 64'(o), 64'(e.ovf));
        chk({tag, "_inx"}, 64'(x), 64'(e.inx));
    endtask

    // One isolated operation on all instances; returns with results on the outputs
    task automatic do_op(input logic [23:0] p24, input logic [23:0] q24,
                         input logic [52:0] p53, input logic [52:0] q53,
                         input logic [10:0] p11, input logic [10:0] q11,
                         input logic rm);
        @(negedge clk);
        a24 = p24; b24 = q24; a53 = p53; b53 = q53; a11 = p11; b11 = q11;
        rnd_mode = rm; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("accept_ready", 64'(ir24), 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 chk("lat_early", 64'(ov24), 64'd0);
        @(posedge clk); #1 chk("lat3_24", 64'(ov24), 64'd1);
        chk("lat3_53", 64'(ov53), 64'd1);
        chk("lat3_11", 64'(ov11), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [23:0] va [5];
    logic [23:0] vb [5];
    exp_t        q [$];
    exp_t        e;
    int          sent, got, stall_left, stall_cycles;
    bit          seen, stale;

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rnd_mode = 1'b0;
        a24 = '0; b24 = '0; a53 = '0; b53 = '0; a11 = '0; b11 = '0;
        #12;
        chk("rst_ov24", 64'(ov24), 64'd0);
        chk("rst_ov53", 64'(ov53), 64'd0);
        chk("rst_ov11", 64'(ov11), 64'd0);
        chk_out("rst24", 64'(r24), n24, o24, x24, mk(0, 0, 0, 64'd0));
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(ir24), 64'd1);

        // 1.0 x 1.0
        do_op(24'h800000, 24'h800000, 53'h10000000000000, 53'h10000000000000,
              11'h400, 11'h400, 1'b0);
        chk_out("one24", 64'(r24), n24, o24, x24, mk(0, 0, 0, 64'h0));
        chk_out("one53", 64'(r53), n53, o53, x53, mk(0, 0, 0, 64'h0));
        chk_out("one11", 64'(r11), n11, o11, x11, mk(0, 0, 0, 64'h0));

        // 1.5 x 1.5
        do_op(24'hC00000, 24'hC00000, 53'h18000000000000, 53'h18000000000000,
              11'h600, 11'h600, 1'b0);
        chk_out("sq15_24", 64'(r24), n24, o24, x24, mk(1, 0, 0, 64'h100000));
        chk_out("sq15_53", 64'(r53), n53, o53, x53, mk(1, 0, 0, 64'h2000000000000));
        chk_out("sq15_11", 64'(r11), n11, o11, x11, mk(1, 0, 0, 64'h80));

        // all-ones operands: sticky only, no round-up
        do_op(24'hFFFFFF, 24'hFFFFFF, 53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF,
              11'h7FF, 11'h7FF, 1'b0);
        chk_out("max24", 64'(r24), n24, o24, x24, mk(1, 0, 1, 64'h7FFFFE));
        chk_out("max53", 64'(r53), n53, o53, x53, mk(1, 0, 1, 64'hFFFFFFFFFFFFE));
        chk_out("max11", 64'(r11), n11, o11, x11, mk(1, 0, 1, 64'h3FE));

        // exact tie with odd LSB rounds up to even
        do_op(24'h800001, 24'hC00000, 53'h10000000000001, 53'h18000000000000,
              11'h401, 11'h600, 1'b0);
        chk_out("tie24", 64'(r24), n24, o24, x24, mk(0, 0, 1, 64'h400002));
        chk_out("tie53", 64'(r53), n53, o53, x53, mk(0, 0, 1, 64'h8000000000002));
        chk_out("tie11", 64'(r11), n11, o11, x11, mk(0, 0, 1, 64'h202));

        // rounding carries out of the fraction (hand case at 11 bits)
        do_op(24'hB504F3, 24'hB504F3, 53'h16A09E667F3BCD, 53'h16A09E667F3BCD,
              11'h5A8, 11'h5A8, 1'b0);
        chk_out("ovf11", 64'(r11), n11, o11, x11, mk(0, 1, 1, 64'h0));
        chk_out("ovf24", 64'(r24), n24, o24, x24, model(24, 64'(a24), 64'(b24), 1'b0));
        chk_out("ovf53", 64'(r53), n53, o53, x53, model(53, 64'(a53), 64'(b53), 1'b0));

`ifdef FP_MUL_ROUND_MODE_EN
        do_op(24'h800001, 24'hC00000, 53'h10000000000001, 53'h18000000000000,
              11'h401, 11'h600, 1'b1);
        chk_out("trunc_tie24", 64'(r24), n24, o24, x24, mk(0, 0, 1, 64'h400001));
        chk_out("trunc_tie53", 64'(r53), n53, o53, x53, mk(0, 0, 1, 64'h8000000000001));
        chk_out("trunc_tie11", 64'(r11), n11, o11, x11, mk(0, 0, 1, 64'h201));
        do_op(24'hB504F3, 24'hB504F3, 53'h16A09E667F3BCD, 53'h16A09E667F3BCD,
              11'h5A8, 11'h5A8, 1'b1);
        chk_out("trunc_ovf11", 64'(r11), n11, o11, x11, mk(0, 0, 1, 64'h3FF));
`endif

        // random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            do_op({1'b1, 23'($urandom)}, {1'b1, 23'($urandom)},
                  {1'b1, 20'($urandom), 32'($urandom)}, {1'b1, 20'($urandom), 32'($urandom)},
                  {1'b1, 10'($urandom)}, {1'b1, 10'($urandom)}, 1'b0);
            chk_out("rnd24", 64'(r24), n24, o24, x24, model(24, 64'(a24), 64'(b24), 1'b0));
            chk_out("rnd53", 64'(r53), n53, o53, x53, model(53, 64'(a53), 64'(b53), 1'b0));
            chk_out("rnd11", 64'(r11), n11, o11, x11, model(11, 64'(a11), 64'(b11), 1'b0));
        end

        // drain, then stream 5 pairs with a 4-cycle output stall
        @(negedge clk);
        @(negedge clk);
        va[0] = 24'h800000; vb[0] = 24'h800000;
        va[1] = 24'hC00000; vb[1] = 24'hC00000;
        va[2] = 24'hFFFFFF; vb[2] = 24'hFFFFFF;
        va[3] = 24'h800001; vb[3] = 24'hC00000;
        va[4] = 24'hABCDEF; vb[4] = 24'h912345;
        sent = 0; got = 0; stall_left = 0; stall_cycles = 0; seen = 1'b0;
        rnd_mode = 1'b0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (ov24 && !seen) begin
                seen = 1'b1;
                stall_left = 4;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            in_valid = (sent < 5);
            if (sent < 5) begin
                a24 = va[sent]; b24 = vb[sent];
            end
            #1;
            if (ov24 && !out_ready) begin
                stall_cycles++;
                chk("bp_in_ready", 64'(ir24), 64'd0);
            end
            if (ov24 && out_ready) begin
                if (q.size() == 0) begin
                    chk("bp_extra", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk_out("bp", 64'(r24), n24, o24, x24, e);
                end
                got++;
            end
            if (in_valid && ir24) begin
                q.push_back(model(24, 64'(a24), 64'(b24), 1'b0));
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", 64'(sent), 64'd5);
        chk("bp_got", 64'(got), 64'd5);
        chk("bp_stall", 64'(stall_cycles), 64'd4);
        @(negedge clk);
        #1 chk("bp_no_dup", 64'(ov24), 64'd0);

        // reset with three operations in flight
        @(negedge clk);
        in_valid = 1'b1; a24 = 24'hC00000; b24 = 24'hC00000;
        @(negedge clk) a24 = 24'hFFFFFF;
        @(negedge clk) a24 = 24'h800001;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 rstn = 1'b0;
        #1 chk("mid_rst_ov24", 64'(ov24), 64'd0);
        chk("mid_rst_ov53", 64'(ov53), 64'd0);
        chk("mid_rst_res24", 64'(r24), 64'd0);
        @(negedge clk);
        @(negedge clk) rstn = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ov24 !== 1'b0 || ov53 !== 1'b0 || ov11 !== 1'b0) stale = 1'b1;
        end
        chk("mid_rst_stale", 64'(stale), 64'd0);
        chk("mid_rst_in_ready", 64'(ir24), 64'd1);

        // still functional after reset
        do_op(24'hC00000, 24'hC00000, 53'h18000000000000, 53'h18000000000000,
              11'h600, 11'h600, 1'b0);
        chk_out("post24", 64'(r24), n24, o24, x24, mk(1, 0, 0, 64'h100000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
